// File: rtl/brq_pkg.sv
// rtl/brq_pkg.sv - shared types and constants for the boot-loading instruction memory
package brq_pkg;

  typedef enum logic [1:0] {
    S_CNT  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2
  } brq_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          LDR_BYTE_W = 8;

endpackage

// File: rtl/ldr_word_pack.sv
// rtl/ldr_word_pack.sv - packs little-endian loader bytes into 32-bit words
module ldr_word_pack
  import brq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [LDR_BYTE_W-1:0] byte_tdata,
  input  logic                  byte_tvalid,
  output logic [31:0]           word_tdata,
  output logic                  word_tvalid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;

  // The word is presented combinationally with its 4th byte so the consumer
  // can commit it on the same edge that accepts that byte.
  assign word_tdata  = {byte_tdata, shreg_q};
  assign word_tvalid = byte_tvalid && !clear && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shreg_d = '0;
    end else if (byte_tvalid) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {byte_tdata, shreg_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory with UART boot loader and core reset hold
module imem_ctrl
  import brq_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                  brq_clk,
  input  logic                  brq_rst_n,
  input  logic                  boot_skip,
  input  logic [AddrWidth-1:0]  inst_mem_address,
  output logic [DataWidth-1:0]  inst_mem_data,
  input  logic [LDR_BYTE_W-1:0] ldr_byte,
  input  logic                  ldr_valid,
  output logic                  ldr_ready,
  output logic                  ldr_done,
  output logic                  core_rst
);

  localparam logic [AddrWidth:0] MaxWords   = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0] OneWord    = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [31:0]        MaxWords32 = 32'(MaxWords);

  brq_state_e           state_q, state_d;
  logic [AddrWidth:0]   n_q, n_d;
  logic [AddrWidth:0]   waddr_q, waddr_d;
  logic                 started_q, started_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 core_rst_q, core_rst_d;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] mem [2**AddrWidth];

  logic        byte_acc;
  logic        pack_clear;
  logic        word_tvalid;
  logic [31:0] word_tdata;
  logic        mem_we;

  assign byte_acc   = ldr_valid && ready_q;
  assign pack_clear = (state_q == S_RUN);

  ldr_word_pack u_pack (
    .clk         (brq_clk),
    .rst_n       (brq_rst_n),
    .clear       (pack_clear),
    .byte_tdata  (ldr_byte),
    .byte_tvalid (byte_acc),
    .word_tdata  (word_tdata),
    .word_tvalid (word_tvalid)
  );

  // started_q holds off boot_skip for one cycle after reset release, so the
  // first post-reset cycle only decides whether the loader opens.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    waddr_d   = waddr_q;
    started_d = 1'b1;
    mem_we    = 1'b0;
    case (state_q)
      S_CNT: begin
        if (!started_q) begin
          state_d = S_CNT;
        end else if (boot_skip) begin
          state_d = S_RUN;
        end else if (word_tvalid) begin
          n_d     = (word_tdata > MaxWords32) ? MaxWords : word_tdata[AddrWidth:0];
          waddr_d = '0;
          state_d = (word_tdata == 32'd0) ? S_RUN : S_DATA;
        end
      end
      S_DATA: begin
        if (word_tvalid) begin
          mem_we  = brq_rst_n;
          waddr_d = waddr_q + OneWord;
          if (waddr_q == n_q - OneWord) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    ready_d    = (state_d == S_CNT) ? !boot_skip : (state_d == S_DATA);
    done_d     = (state_d == S_RUN);
    core_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge brq_clk) begin
    if (!brq_rst_n) begin
      state_q    <= S_CNT;
      n_q        <= '0;
      waddr_q    <= '0;
      started_q  <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      waddr_q    <= waddr_d;
      started_q  <= started_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
    end
  end

  // Memory has no reset so a reset mid-load keeps words already written.
  always_ff @(posedge brq_clk) begin
    if (mem_we) begin
      mem[waddr_q[AddrWidth-1:0]] <= DataWidth'(word_tdata);
    end
  end

  always_ff @(posedge brq_clk) begin
    if (!brq_rst_n) begin
      rdata_q <= '0;
    end else if (state_q == S_RUN) begin
      rdata_q <= mem[inst_mem_address];
    end else begin
      rdata_q <= DataWidth'(NOP_INSN);
    end
  end

  assign inst_mem_data = rdata_q;
  assign ldr_ready     = ready_q;
  assign ldr_done      = done_q;
  assign core_rst      = core_rst_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - randomized scoreboard bench for imem_ctrl
module tb_imem_ctrl;
  import brq_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot_skip = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    ldr_byte = '0;
  logic          ldr_valid = 1'b0;
  logic [31:0]   inst_mem_data;
  logic          ldr_ready;
  logic          ldr_done;
  logic          core_rst;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit            has_fetch;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            ready;
    bit            done;
    bit            crst;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: counts accepted bytes and derives everything from that.
  bit          m_started, m_done, m_ready;
  int          m_k, m_n;
  logic [7:0]  m_acc[$];
  logic [31:0] ref_mem[int];

  imem_ctrl #(.DataWidth(32), .AddrWidth(AW)) dut (
    .brq_clk          (clk),
    .brq_rst_n        (rst_n),
    .boot_skip        (boot_skip),
    .inst_mem_address (addr),
    .inst_mem_data    (inst_mem_data),
    .ldr_byte         (ldr_byte),
    .ldr_valid        (ldr_valid),
    .ldr_ready        (ldr_ready),
    .ldr_done         (ldr_done),
    .core_rst         (core_rst)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_started = 0;
    m_done    = 0;
    m_ready   = 0;
    m_k       = 0;
    m_n       = 0;
    m_acc.delete();
  endtask

  // Called at a negedge: drives one cycle, predicts the outputs after the next posedge.
  task automatic cycle(input bit vld, input logic [7:0] b, output bit acc);
    exp_t        e;
    int          a;
    logic [31:0] w;
    longint      wl;
    case ($urandom_range(0, 3))
      0:       a = 0;
      1:       a = 1;
      2:       a = 5;
      default: a = int'($urandom_range(0, (1 << AW) - 1));
    endcase
    e.addr      = a[AW-1:0];
    e.has_fetch = 1'b1;
    e.data      = NOP_INSN;
    if (m_done) begin
      if (ref_mem.exists(a)) e.data = ref_mem[a];
      else e.has_fetch = 1'b0;
    end
    addr      = a[AW-1:0];
    ldr_valid = vld;
    ldr_byte  = b;
    acc       = vld && m_ready;
    if (!m_started) begin
      m_started = 1;
    end else if (!m_done) begin
      if (m_k < 4 && boot_skip) begin
        m_done = 1;
      end else if (acc) begin
        m_acc.push_back(b);
        m_k++;
        if (m_k % 4 == 0) begin
          w = {m_acc[m_k-1], m_acc[m_k-2], m_acc[m_k-3], m_acc[m_k-4]};
          if (m_k == 4) begin
            wl  = longint'(w);
            m_n = (wl > longint'(1 << AW)) ? (1 << AW) : int'(wl);
            if (m_n == 0) m_done = 1;
          end else begin
            ref_mem[m_k / 4 - 2] = w;
            if (m_k == 4 + 4 * m_n) m_done = 1;
          end
        end
      end
    end
    m_ready = !m_done && !(m_k < 4 && boot_skip);
    e.ready = m_ready;
    e.done  = m_done;
    e.crst  = !m_done;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit bs);
    rst_n     = 1'b0;
    ldr_valid = 1'b0;
    boot_skip = bs;
    repeat (3) @(negedge clk);
    chk("rst_ldr_ready", ldr_ready, 0);
    chk("rst_ldr_done", ldr_done, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_inst_mem_data", inst_mem_data, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [7:0] bytes[$], input int max_gap);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < bytes.size()) begin
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 8'($urandom), acc);
      cycle(1'b1, bytes[i], acc);
      if (acc) i++;
      guard++;
      if (guard > 400) begin
        n_total++;
        $display("FAIL send_timeout actual=%0d bytes accepted required=%0d", i, bytes.size());
        break;
      end
    end
  endtask

  task automatic idle(input int n, input bit vld);
    bit acc;
    repeat (n) cycle(vld, 8'($urandom), acc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ldr_ready", ldr_ready, e.ready);
        chk("ldr_done", ldr_done, e.done);
        chk("core_rst", core_rst, e.crst);
        if (e.has_fetch) chk($sformatf("fetch[%0d]", e.addr), inst_mem_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] s32[$];
    logic [7:0] s0[$];
    logic [7:0] sr[$];
    logic [7:0] sp[$];
    int         nw;
    s32 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
            8'h13, 8'h01, 8'h20, 8'h00};
    s0  = '{8'h00, 8'h00, 8'h00, 8'h00};
    model_reset();
    @(negedge clk);

    // Basic two-word load, then fetches from the loaded words.
    do_reset(1'b0);
    send(s32, 0);
    idle(8, 1'b1);

    // Empty image: straight to run, memory untouched, bytes ignored.
    do_reset(1'b0);
    send(s0, 0);
    idle(8, 1'b1);

    // Same image with random valid gaps.
    do_reset(1'b0);
    send(s32, 5);
    idle(6, 1'b0);

    // Random image of 1..6 random words with gaps.
    do_reset(1'b0);
    nw = int'($urandom_range(1, 6));
    sr.delete();
    for (int i = 0; i < 4; i++) sr.push_back(8'(nw >> (8 * i)));
    for (int i = 0; i < 4 * nw; i++) sr.push_back(8'($urandom));
    send(sr, 3);
    idle(10, 1'b1);

    // Reset after 6 bytes, then the full image must land at address 0 again.
    do_reset(1'b0);
    sp.delete();
    for (int i = 0; i < 6; i++) sp.push_back(s32[i]);
    send(sp, 2);
    do_reset(1'b0);
    send(s32, 1);
    idle(8, 1'b1);

    // Boot skip: run from preloaded contents, loader never opens.
    do_reset(1'b1);
    idle(10, 1'b1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter DataWidth, default 32: fetch data width in bits.
REQ-002 Parameter AddrWidth, default 15: fetch word-address width; memory depth is 2**AddrWidth words.
REQ-003 brq_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 brq_rst_n  input  1  reset, synchronous and active-low.
REQ-005 boot_skip  input  1  when 1, skip loading and run from existing memory contents; sampled on the first cycle after reset release.
REQ-006 inst_mem_address  input  AddrWidth  word address from fetch unit.
REQ-007 inst_mem_data  output  DataWidth  registered fetch data.
REQ-008 ldr_byte  input  8  boot-load byte from UART receiver.
REQ-009 ldr_valid  input  1  ldr_byte valid.
REQ-010 ldr_ready  output  1  loader can accept a byte.
REQ-011 ldr_done  output  1  load complete, level.
REQ-012 core_rst  output  1  active-high reset to core, held until load complete.

Function
REQ-013 A byte is accepted only on a cycle where ldr_valid=1 and ldr_ready=1; ldr_valid gaps of any length do not disturb assembly.
REQ-014 The FSM has three states: S_CNT, S_DATA and S_RUN.
REQ-015 S_CNT: collect 4 bytes, little-endian, into word count N.
  - N=0 -> S_RUN.
  - Otherwise -> S_DATA.
  - Transition occurs on the edge that accepts the 4th byte.
REQ-016 N greater than 2**AddrWidth is clamped to 2**AddrWidth.
REQ-017 S_DATA: every 4 accepted bytes (little-endian, first byte = bits 7:0) form one word.
  - The word is written to memory at the write address on the edge accepting its 4th byte.
  - The write address starts at 0 and increments by 1 per word.
REQ-018 S_DATA -> S_RUN on the edge that writes word N-1.
REQ-019 From S_CNT, boot_skip=1 -> S_RUN on the next edge; boot_skip has no effect in S_DATA or S_RUN.
REQ-020 ldr_ready=1 in S_CNT and S_DATA, and 0 in S_RUN; bytes offered in S_RUN are ignored.
REQ-021 ldr_done=1 and core_rst=0 exactly when the state is S_RUN; both are registered and change on the transitioning edge.
REQ-022 In S_RUN: inst_mem_data <= mem[inst_mem_address] every cycle, one-cycle read latency, no read enable.
REQ-023 Outside S_RUN, inst_mem_data is 32'h0000_0013 (NOP) on the cycle after any address.
REQ-024 No read/write collision handling is required, because writes occur only outside S_RUN.
REQ-025 The byte counter (2 bits) wraps 3->0 per word; the write address counter is AddrWidth+1 bits and never wraps before the clamped N is reached.

Reset
REQ-026 While brq_rst_n=0, the following values are held:
  - state = S_CNT
  - byte counter = 0
  - write address = 0
  - N = 0
  - inst_mem_data = 0
  - ldr_ready = 0
  - ldr_done = 0
  - core_rst = 1
REQ-027 ldr_ready rises on the first cycle after reset release unless boot_skip=1.
REQ-028 Reset asserted mid-load aborts the load and returns to S_CNT; words already written remain in memory and are not cleared.

Structure
REQ-029 The shared package brq_pkg holds:
  - the FSM state enum (S_CNT, S_DATA, S_RUN)
  - the NOP constant 32'h0000_0013
  - the loader byte width constant 8
REQ-030 Byte-to-word packing is one sub-module, ldr_word_pack: byte in, valid in, 32-bit word out, word-valid pulse, clear input.
REQ-031 The memory array is inferred in imem_ctrl as a single-port-write / single-port-read synchronous RAM, suitable for FPGA block RAM.

Verification
REQ-032 boot_skip=0, bytes 02 00 00 00 93 00 10 00 13 01 20 00 ->
  - ldr_done=1 and core_rst=0 after the 12th byte is accepted.
  - Address 0 reads 0x00100093 one cycle later.
  - Address 1 reads 0x00200113 one cycle later.
REQ-033 Bytes 00 00 00 00 -> S_RUN after the 4th byte; memory is unchanged; ldr_ready=0 afterwards.
REQ-034 Same stream as REQ-032 with random 0-5 cycle ldr_valid gaps -> identical memory contents and ldr_done timing relative to the last accepted byte.
REQ-035 Reset pulsed after 6 bytes, then the full REQ-032 stream -> correct contents at addresses 0 and 1 with write address restarted at 0.
REQ-036 boot_skip=1 at reset release -> core_rst=0 two cycles after release; ldr_ready remains 0; fetches return preloaded contents.
REQ-037 Fetch of address 5 during S_DATA -> inst_mem_data=0x00000013 on the next cycle.
